rr_grant_arbiter: RTL and testbench
===================================

// Module: rr_grant_arbiter
// PURPOSE
//  N-way round-robin arbiter granting one shared resource to one requester at a time.
//  Successor to the fixed 2-requester grant FSM: parameterised width, fair rotation,
//  bounded hold time. Sits between bus/resource requesters and the shared datapath.
//  Exactly one gnt bit or none is high on any cycle.
// PARAMETERS
//  NUM_REQ   4   number of requesters, 2..16
//  MAX_HOLD  16  max consecutive grant cycles per tenure; 0 = unlimited
//  ID_W      $clog2(NUM_REQ)  derived, not overridden
// PORTS
//  clock          in   1        clock, all logic on posedge
//  reset          in   1        synchronous, active-high
//  req            in   NUM_REQ  level request, held high while resource wanted
//  gnt            out  NUM_REQ  one-hot grant, registered
//  gnt_valid      out  1        OR of gnt, registered
//  gnt_id         out  ID_W     index of granted requester; 0 when gnt_valid=0
//  timeout_pulse  out  1        1-cycle pulse when a tenure is cut by MAX_HOLD
//  busy           out  1        state != IDLE
// BEHAVIOUR
//  Reset: gnt=0, gnt_valid=0, gnt_id=0, timeout_pulse=0, busy=0, state=IDLE,
//   rr_ptr=0, hold_cnt=0. Reset mid-grant drops gnt on the next edge, no timeout pulse.
//  States (state_t): IDLE, GRANT, RELEASE.
//  IDLE: if |req, pick first i with req[i]=1 searching rr_ptr, rr_ptr+1, ... mod NUM_REQ;
//   next edge: gnt[i]=1, gnt_id=i, hold_cnt=1, -> GRANT. No req: stay IDLE.
//   Latency: req sampled high in IDLE at edge n -> gnt high after edge n+1.
//  GRANT (owner = gnt_id):
//   req[owner]=0                         -> RELEASE, gnt cleared same edge.
//   MAX_HOLD!=0 && hold_cnt==MAX_HOLD && req[owner]=1
//                                        -> RELEASE, gnt cleared, timeout_pulse=1.
//   else stay, hold_cnt++ (saturates; width $clog2(MAX_HOLD+1), min 1).
//   Other requesters' req changes ignored during GRANT.
//  RELEASE: all gnt low for exactly this cycle (bus turnaround);
//   rr_ptr <= (owner+1) mod NUM_REQ (wrap NUM_REQ-1 -> 0); -> IDLE.
//  Timed-out owner still requesting is re-granted only if no other req set at
//   next IDLE evaluation (pointer has moved past it).
//  Grant-to-grant gap: 2 cycles with no gnt (RELEASE + IDLE).
//  Simultaneous req drop and hold limit on same cycle: treat as normal release,
//   timeout_pulse=0.
//  Non-power-of-2 NUM_REQ: indices >= NUM_REQ never produced; pointer wraps at NUM_REQ.
//  MAX_HOLD=0: no timeout; timeout_pulse tied 0.
//  All outputs registered; no combinational path req -> gnt.
// STRUCTURE
//  arb_pkg: typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
//   function rr_pick(req, ptr) returning {found, idx} for reuse by other arbiters.
//  Sub-module rr_priority_pick: combinational rotate/priority-encode/unrotate,
//   params NUM_REQ; ports req, ptr -> found, idx. FSM, counter, pointer stay in top.
// TESTING
//  1 NUM_REQ=4, req=4'b1111 held: gnt order 0,1,2,3,0 each MAX_HOLD=16 cycles,
//    timeout_pulse each tenure, 2 idle cycles between grants.
//  2 req=4'b0100 one cycle in IDLE, drop next: gnt=4'b0100 one cycle, RELEASE, IDLE,
//    rr_ptr=3.
//  3 only req[3] held, MAX_HOLD=4: gnt[3] 4 cycles, timeout, gap 2, re-grant 3;
//    pointer wrap 3->0 checked.
//  4 reset asserted on 3rd GRANT cycle: next edge all outputs 0, state IDLE, rr_ptr=0.
//  5 req[1] drops exactly when hold_cnt==MAX_HOLD: release, timeout_pulse stays 0.
//  6 NUM_REQ=3, MAX_HOLD=0, random req 10k cycles: assert onehot0(gnt), gnt_id match,
//    no starvation >2*NUM_REQ tenures while req held.

Source files
------------

// File: rtl/rr_grant_arbiter_pkg.sv
// arb_pkg: shared types and the round-robin pick function for arbiters.
//   state_t  : arbiter FSM states (IDLE, GRANT, RELEASE)
//   pick_t   : {found, idx} result of a round-robin search
//   rr_pick  : first set request at or after ptr, wrapping at num_req.
//              Vectors are sized for the largest supported arbiter (16);
//              callers zero-extend their request vector and pointer.
package arb_pkg;

  localparam int MAX_REQ  = 16;
  localparam int MAX_ID_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
  } pick_t;

  // Rotate the search origin to ptr, take the first set bit, and map the
  // position back to an absolute index. Positions >= num_req are never visited.
  function automatic pick_t rr_pick(
    input logic [MAX_REQ-1:0]  req,
    input logic [MAX_ID_W-1:0] ptr,
    input int                  num_req
  );
    pick_t res;
    int    pos;
    res = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      pos = (int'(ptr) + k) % num_req;
      if ((k < num_req) && !res.found && req[pos[MAX_ID_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = pos[MAX_ID_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin selector.
//   i_req   [NUM_REQ-1:0]  request vector
//   i_ptr   [ID_W-1:0]     index searched first
//   o_found                at least one request set
//   o_idx   [ID_W-1:0]     selected index (0 when o_found=0)
module rr_priority_pick
  import arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic               o_found,
  output logic [ID_W-1:0]    o_idx
);

  logic [MAX_REQ-1:0]  w_req_ext;
  logic [MAX_ID_W-1:0] w_ptr_ext;
  pick_t               w_pick;
  logic                w_unused_pick;

  always_comb begin
    w_req_ext                = '0;
    w_req_ext[NUM_REQ-1:0]   = i_req;
    w_ptr_ext                = '0;
    w_ptr_ext[ID_W-1:0]      = i_ptr;
    w_pick                   = rr_pick(w_req_ext, w_ptr_ext, NUM_REQ);
  end

  assign o_found = w_pick.found;
  assign o_idx   = w_pick.idx[ID_W-1:0];

  // Upper index bits are always zero for small arbiters.
  assign w_unused_pick = ^w_pick;

endmodule

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: N-way round-robin arbiter for one shared resource with a
// bounded hold time per tenure. All outputs are registered.
//   clock            posedge clock
//   reset            synchronous, active-high
//   i_req            [NUM_REQ-1:0] level requests
//   o_gnt            [NUM_REQ-1:0] one-hot (or zero) grant
//   o_gnt_valid      OR of o_gnt
//   o_gnt_id         [ID_W-1:0] granted index, 0 when no grant
//   o_timeout_pulse  one-cycle pulse when a tenure is cut at MAX_HOLD cycles
//   o_busy           FSM not in IDLE
//
// state   | meaning
// IDLE    | no grant; pick next requester from rr pointer
// GRANT   | owner holds the resource, hold counter running
// RELEASE | one turnaround cycle with no grant, then back to IDLE
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_HOLD = 16,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_gnt_valid,
  output logic [ID_W-1:0]    o_gnt_id,
  output logic               o_timeout_pulse,
  output logic               o_busy
);

  localparam int                HOLD_W   = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
  localparam logic [ID_W-1:0]   LAST_ID  = ID_W'(NUM_REQ - 1);

  state_t              r_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [NUM_REQ-1:0]  r_gnt;
  logic                r_gnt_valid;
  logic [ID_W-1:0]     r_gnt_id;
  logic                r_timeout_pulse;
  logic                r_busy;

  logic                w_found;
  logic [ID_W-1:0]     w_pick_idx;
  logic [NUM_REQ-1:0]  w_pick_onehot;
  logic                w_owner_req;
  logic                w_hold_hit;
  logic [ID_W-1:0]     w_next_ptr;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_req   (i_req),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

  assign w_pick_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
  assign w_owner_req   = i_req[r_gnt_id];
  assign w_hold_hit    = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LIM);
  assign w_next_ptr    = (r_gnt_id == LAST_ID) ? '0 : r_gnt_id + 1'b1;

  // The pointer advance is captured on the GRANT exit edge because o_gnt_id
  // is cleared there; the pointer is only consumed in IDLE, after RELEASE,
  // so the visible arbitration order is the same as advancing in RELEASE.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= IDLE;
      r_rr_ptr        <= '0;
      r_hold_cnt      <= '0;
      r_gnt           <= '0;
      r_gnt_valid     <= 1'b0;
      r_gnt_id        <= '0;
      r_timeout_pulse <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_timeout_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_gnt       <= w_pick_onehot;
            r_gnt_valid <= 1'b1;
            r_gnt_id    <= w_pick_idx;
            r_hold_cnt  <= HOLD_W'(1);
            r_busy      <= 1'b1;
            r_state     <= GRANT;
          end
        end
        GRANT: begin
          if (!w_owner_req || w_hold_hit) begin
            // A dropped request wins over the hold limit: no timeout pulse.
            r_timeout_pulse <= w_owner_req;
            r_gnt           <= '0;
            r_gnt_valid     <= 1'b0;
            r_gnt_id        <= '0;
            r_hold_cnt      <= '0;
            r_rr_ptr        <= w_next_ptr;
            r_state         <= RELEASE;
          end else if (r_hold_cnt != {HOLD_W{1'b1}}) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        RELEASE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_gnt       <= '0;
          r_gnt_valid <= 1'b0;
          r_gnt_id    <= '0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign o_gnt           = r_gnt;
  assign o_gnt_valid     = r_gnt_valid;
  assign o_gnt_id        = r_gnt_id;
  assign o_timeout_pulse = r_timeout_pulse;
  assign o_busy          = r_busy;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
module tb_rr_grant_arbiter;
  import arb_pkg::*;

  logic clock;
  logic reset;

  // dut: NUM_REQ=4, MAX_HOLD=16
  logic [3:0] req_a;
  logic [3:0] gnt_a;
  logic       valid_a;
  logic [1:0] id_a;
  logic       to_a;
  logic       busy_a;

  // dut_h4: NUM_REQ=4, MAX_HOLD=4
  logic [3:0] req_b;
  logic [3:0] gnt_b;
  logic       valid_b;
  logic [1:0] id_b;
  logic       to_b;
  logic       busy_b;

  // dut_3: NUM_REQ=3, MAX_HOLD=0
  logic [2:0] req_c;
  logic [2:0] gnt_c;
  logic       valid_c;
  logic [1:0] id_c;
  logic       to_c;
  logic       busy_c;

  int checks;
  int failures;

  rr_grant_arbiter #(.NUM_REQ(4), .MAX_HOLD(16)) dut (
    .clock(clock), .reset(reset), .i_req(req_a), .o_gnt(gnt_a),
    .o_gnt_valid(valid_a), .o_gnt_id(id_a), .o_timeout_pulse(to_a), .o_busy(busy_a)
  );

  rr_grant_arbiter #(.NUM_REQ(4), .MAX_HOLD(4)) dut_h4 (
    .clock(clock), .reset(reset), .i_req(req_b), .o_gnt(gnt_b),
    .o_gnt_valid(valid_b), .o_gnt_id(id_b), .o_timeout_pulse(to_b), .o_busy(busy_b)
  );

  rr_grant_arbiter #(.NUM_REQ(3), .MAX_HOLD(0)) dut_3 (
    .clock(clock), .reset(reset), .i_req(req_c), .o_gnt(gnt_c),
    .o_gnt_valid(valid_c), .o_gnt_id(id_c), .o_timeout_pulse(to_c), .o_busy(busy_c)
  );

  // {gnt, gnt_valid, gnt_id, timeout_pulse, busy}
  logic [8:0] obs_a;
  logic [8:0] obs_b;
  assign obs_a = {gnt_a, valid_a, id_a, to_a, busy_a};
  assign obs_b = {gnt_b, valid_b, id_b, to_b, busy_b};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs_a !== 9'b0) begin
      failures++;
      $display("FAIL reset_outputs_a: got %b want %b", obs_a, 9'b0);
    end
    checks++;
    if (obs_b !== 9'b0 || {gnt_c, valid_c, id_c, to_c, busy_c} !== 8'b0) begin
      failures++;
      $display("FAIL reset_outputs_bc: got b=%b c=%b want 0", obs_b, {gnt_c, valid_c, id_c, to_c, busy_c});
    end
    checks++;
    if (dut.r_state !== IDLE || dut.r_rr_ptr !== 2'd0 || dut.r_hold_cnt !== 5'd0) begin
      failures++;
      $display("FAIL reset_state: got state=%0d ptr=%0d hold=%0d want 0 0 0",
               dut.r_state, dut.r_rr_ptr, dut.r_hold_cnt);
    end
  endtask

  // All four requesting: rotation 0,1,2,3,0 with 16-cycle tenures and a 2-cycle gap.
  task automatic test_rotation_timeout();
    logic [8:0] exp;
    do_reset();
    req_a = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      tick();
      exp = {4'b0001 << (t % 4), 1'b1, 2'(t % 4), 1'b0, 1'b1};
      checks++;
      if (obs_a !== exp) begin
        failures++;
        $display("FAIL rot_grant_start t=%0d: got %b want %b", t, obs_a, exp);
      end
      for (int k = 1; k < 16; k++) begin
        tick();
        checks++;
        if (obs_a !== exp) begin
          failures++;
          $display("FAIL rot_grant_hold t=%0d k=%0d: got %b want %b", t, k, obs_a, exp);
        end
      end
      tick();
      checks++;
      if (obs_a !== 9'b0000_0_00_1_1) begin
        failures++;
        $display("FAIL rot_release_timeout t=%0d: got %b want %b", t, obs_a, 9'b0000_0_00_1_1);
      end
      tick();
      checks++;
      if (obs_a !== 9'b0) begin
        failures++;
        $display("FAIL rot_idle_gap t=%0d: got %b want %b", t, obs_a, 9'b0);
      end
    end
    req_a = 4'b0000;
    tick();
  endtask

  // One-cycle request from 2: single-cycle grant, release, pointer to 3.
  // Then reset on the third grant cycle of a fresh tenure.
  task automatic test_short_req_and_reset_mid_grant();
    do_reset();
    req_a = 4'b0100;
    tick();
    checks++;
    if (obs_a !== 9'b0100_1_10_0_1) begin
      failures++;
      $display("FAIL short_grant: got %b want %b", obs_a, 9'b0100_1_10_0_1);
    end
    req_a = 4'b0000;
    tick();
    checks++;
    if (obs_a !== 9'b0000_0_00_0_1) begin
      failures++;
      $display("FAIL short_release: got %b want %b", obs_a, 9'b0000_0_00_0_1);
    end
    tick();
    checks++;
    if (obs_a !== 9'b0 || dut.r_state !== IDLE || dut.r_rr_ptr !== 2'd3) begin
      failures++;
      $display("FAIL short_idle_ptr: got out=%b state=%0d ptr=%0d want 0 0 3",
               obs_a, dut.r_state, dut.r_rr_ptr);
    end
    // Pointer at 3 with req 0,1,2: search 3,0 -> requester 0.
    req_a = 4'b0111;
    tick();
    checks++;
    if (obs_a !== 9'b0001_1_00_0_1) begin
      failures++;
      $display("FAIL ptr3_pick: got %b want %b", obs_a, 9'b0001_1_00_0_1);
    end
    tick();
    tick();
    checks++;
    if (obs_a !== 9'b0001_1_00_0_1) begin
      failures++;
      $display("FAIL third_grant_cycle: got %b want %b", obs_a, 9'b0001_1_00_0_1);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (obs_a !== 9'b0 || dut.r_state !== IDLE || dut.r_rr_ptr !== 2'd0 || dut.r_hold_cnt !== 5'd0) begin
      failures++;
      $display("FAIL reset_mid_grant: got out=%b state=%0d ptr=%0d hold=%0d want 0 0 0 0",
               obs_a, dut.r_state, dut.r_rr_ptr, dut.r_hold_cnt);
    end
    // Pointer 0 with req 1,3 must pick 1 (a stale pointer of 3 would pick 3).
    reset = 1'b0;
    req_a = 4'b1010;
    tick();
    checks++;
    if (obs_a !== 9'b0010_1_01_0_1) begin
      failures++;
      $display("FAIL post_reset_pick: got %b want %b", obs_a, 9'b0010_1_01_0_1);
    end
    req_a = 4'b0000;
    tick();
    tick();
  endtask

  // MAX_HOLD=4, only requester 3: 4-cycle tenure, timeout, wrap to 0, re-grant 3.
  task automatic test_single_req_wrap();
    do_reset();
    req_b = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (obs_b !== 9'b1000_1_11_0_1) begin
        failures++;
        $display("FAIL h4_grant k=%0d: got %b want %b", k, obs_b, 9'b1000_1_11_0_1);
      end
    end
    tick();
    checks++;
    if (obs_b !== 9'b0000_0_00_1_1) begin
      failures++;
      $display("FAIL h4_timeout: got %b want %b", obs_b, 9'b0000_0_00_1_1);
    end
    tick();
    checks++;
    if (obs_b !== 9'b0 || dut_h4.r_rr_ptr !== 2'd0) begin
      failures++;
      $display("FAIL h4_gap_wrap: got out=%b ptr=%0d want 0 0", obs_b, dut_h4.r_rr_ptr);
    end
    tick();
    checks++;
    if (obs_b !== 9'b1000_1_11_0_1) begin
      failures++;
      $display("FAIL h4_regrant: got %b want %b", obs_b, 9'b1000_1_11_0_1);
    end
    req_b = 4'b0000;
    tick();
    checks++;
    if (obs_b !== 9'b0000_0_00_0_1) begin
      failures++;
      $display("FAIL h4_drop_release: got %b want %b", obs_b, 9'b0000_0_00_0_1);
    end
    tick();
  endtask

  // Requester 1 drops on the same cycle the hold limit is reached.
  task automatic test_drop_at_limit();
    do_reset();
    req_a = 4'b0010;
    tick();
    checks++;
    if (obs_a !== 9'b0010_1_01_0_1) begin
      failures++;
      $display("FAIL limit_grant: got %b want %b", obs_a, 9'b0010_1_01_0_1);
    end
    for (int k = 1; k < 16; k++) tick();
    checks++;
    if (obs_a !== 9'b0010_1_01_0_1 || dut.r_hold_cnt !== 5'd16) begin
      failures++;
      $display("FAIL limit_reached: got out=%b hold=%0d want %b 16", obs_a, dut.r_hold_cnt, 9'b0010_1_01_0_1);
    end
    req_a = 4'b0000;
    tick();
    checks++;
    if (obs_a !== 9'b0000_0_00_0_1) begin
      failures++;
      $display("FAIL limit_drop_no_timeout: got %b want %b", obs_a, 9'b0000_0_00_0_1);
    end
    tick();
    checks++;
    if (obs_a !== 9'b0 || dut.r_rr_ptr !== 2'd2) begin
      failures++;
      $display("FAIL limit_idle_ptr: got out=%b ptr=%0d want 0 2", obs_a, dut.r_rr_ptr);
    end
  endtask

  // NUM_REQ=3, MAX_HOLD=0 under random level requests.
  task automatic test_random_n3();
    int         wait_cnt [3];
    int         tenures;
    int         worst;
    logic       prev_valid;
    logic       new_tenure;
    logic [2:0] req_prev;
    logic [2:0] exp_gnt;
    do_reset();
    tenures    = 0;
    worst      = 0;
    prev_valid = 1'b0;
    for (int i = 0; i < 3; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      req_prev = req_c;
      tick();
      checks++;
      if ($countones(gnt_c) > 1 || (valid_c !== (|gnt_c)) || to_c !== 1'b0) begin
        failures++;
        $display("FAIL rand_onehot cyc=%0d: got gnt=%b valid=%b to=%b want onehot0", cyc, gnt_c, valid_c, to_c);
      end
      exp_gnt = valid_c ? (3'b001 << id_c) : 3'b000;
      checks++;
      if (gnt_c !== exp_gnt || (!valid_c && id_c !== 2'd0)) begin
        failures++;
        $display("FAIL rand_id cyc=%0d: got gnt=%b id=%0d want gnt=%b", cyc, gnt_c, id_c, exp_gnt);
      end
      new_tenure = valid_c && !prev_valid;
      if (new_tenure) tenures++;
      for (int i = 0; i < 3; i++) begin
        if (!req_prev[i]) wait_cnt[i] = 0;
        else if (new_tenure) begin
          if (int'(id_c) == i) wait_cnt[i] = 0;
          else wait_cnt[i]++;
        end
        if (wait_cnt[i] > worst) worst = wait_cnt[i];
      end
      checks++;
      if (worst > 6) begin
        failures++;
        $display("FAIL rand_starvation cyc=%0d: got %0d tenures waited want <= 6", cyc, worst);
      end
      prev_valid = valid_c;
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(7) == 0) req_c[i] = ~req_c[i];
      end
    end
    checks++;
    if (tenures < 100) begin
      failures++;
      $display("FAIL rand_activity: got %0d tenures want >= 100", tenures);
    end
    req_c = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    req_a    = '0;
    req_b    = '0;
    req_c    = '0;
    test_reset();
    test_rotation_timeout();
    test_short_req_and_reset_mid_grant();
    test_single_req_wrap();
    test_drop_at_limit();
    test_random_n3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
